keypad_scanner_4x4: RTL and testbench



---
 rtl/keypad_scanner_4x4.sv | 164 ++++++++++++++++
 tb/tb_keypad_scanner_4x4.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner_4x4.sv
// keypad_scanner_4x4
// Scans a 4x4 active-low matrix keypad one column at a time, debounces
// presses and releases over DEBOUNCE_TICKS scan ticks, and presents a stable
// {row,col} key code with a one-cycle strobe and a held flag.
// Build option: define KEYPAD_SYNC2_EN for a two-flop row synchronizer;
// otherwise a single register stage samples the rows.
module keypad_scanner_4x4 #(
   parameter int CLK_DIV        = 50000,
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_code,
   output logic       key_strobe,
   output logic       key_held
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_TICKS - 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   state_t           state, state_nxt;
   logic [1:0]       col_idx, col_nxt;
   logic [1:0]       row_idx, row_nxt;
   logic [DEB_W-1:0] deb_cnt, deb_nxt;
   logic [3:0]       code_nxt;
   logic             strobe_nxt;
   logic             held_nxt;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [3:0]       row_s;
   logic             row_sel;

   // Lowest-index low row wins when several rows are pulled low together.
   function automatic logic [1:0] low_row(input logic [3:0] rows);
      if (!rows[0])      return 2'd0;
      else if (!rows[1]) return 2'd1;
      else if (!rows[2]) return 2'd2;
      else               return 2'd3;
   endfunction

   logic [3:0] row_p0;
`ifdef KEYPAD_SYNC2_EN
   logic [3:0] row_p1;

   // Two-flop synchronizer; idle (pulled-up) level on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_p0 <= 4'hF;
         row_p1 <= 4'hF;
      end else begin
         row_p0 <= row_in;
         row_p1 <= row_p0;
      end
   end
   assign row_s = row_p1;
`else
   // Single sampling register; idle (pulled-up) level on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) row_p0 <= 4'hF;
      else     row_p0 <= row_in;
   end
   assign row_s = row_p0;
`endif

   // Scan tick divider: counts 0..CLK_DIV-1, tick on the last count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + 1'b1;
   end

   assign tick    = (div_cnt == DIV_LAST);
   assign row_sel = row_s[row_idx];

   // Next-state and output decisions; only tick cycles can change anything.
   always_comb begin
      state_nxt  = state;
      col_nxt    = col_idx;
      row_nxt    = row_idx;
      deb_nxt    = deb_cnt;
      code_nxt   = key_code;
      strobe_nxt = 1'b0;
      held_nxt   = key_held;
      if (tick) begin
         case (state)
            SCAN: begin
               if (row_s != 4'hF) begin
                  row_nxt   = low_row(row_s);
                  deb_nxt   = '0;
                  state_nxt = DEBOUNCE;
               end else begin
                  col_nxt = col_idx + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (!row_sel) begin
                  if (deb_cnt == DEB_LAST) begin
                     state_nxt  = HELD;
                     code_nxt   = {row_idx, col_idx};
                     strobe_nxt = 1'b1;
                     held_nxt   = 1'b1;
                  end else begin
                     deb_nxt = deb_cnt + 1'b1;
                  end
               end else begin
                  // Bounce: resume scanning on the same column.
                  state_nxt = SCAN;
               end
            end
            HELD: begin
               if (row_sel) begin
                  deb_nxt   = '0;
                  state_nxt = RELEASE;
               end
            end
            RELEASE: begin
               if (row_sel) begin
                  if (deb_cnt == DEB_LAST) begin
                     held_nxt  = 1'b0;
                     col_nxt   = col_idx + 2'd1;
                     state_nxt = SCAN;
                  end else begin
                     deb_nxt = deb_cnt + 1'b1;
                  end
               end else begin
                  // Release glitch: key still down, no new strobe.
                  state_nxt = HELD;
               end
            end
            default: state_nxt = SCAN;
         endcase
      end
   end

   // State and registered outputs; col_out is decoded from the next column.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= SCAN;
         col_idx    <= 2'd0;
         row_idx    <= 2'd0;
         deb_cnt    <= '0;
         col_out    <= 4'b1110;
         key_code   <= 4'b0000;
         key_strobe <= 1'b0;
         key_held   <= 1'b0;
      end else begin
         state      <= state_nxt;
         col_idx    <= col_nxt;
         row_idx    <= row_nxt;
         deb_cnt    <= deb_nxt;
         col_out    <= ~(4'b0001 << col_nxt);
         key_code   <= code_nxt;
         key_strobe <= strobe_nxt;
         key_held   <= held_nxt;
      end
   end

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Directed bench for keypad_scanner_4x4 with CLK_DIV=4, DEBOUNCE_TICKS=3 and
// a keypad model that pulls a row low only while its pressed key's column
// is driven low.
module tb_keypad_scanner_4x4;

   localparam int CLK_DIV = 4;
   localparam int DT      = 3;
`ifdef KEYPAD_SYNC2_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 1;
`endif

   logic        clk;
   logic        rst;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic [3:0]  key_code;
   logic        key_strobe;
   logic        key_held;
   logic [15:0] press;          // bit r*4+c = key (r,c) pressed
   int          compared;
   int          mismatched;
   int          strobe_cnt;

   keypad_scanner_4x4 #(.CLK_DIV(CLK_DIV), .DEBOUNCE_TICKS(DT)) dut (
      .clk        (clk),
      .rst        (rst),
      .row_in     (row_in),
      .col_out    (col_out),
      .key_code   (key_code),
      .key_strobe (key_strobe),
      .key_held   (key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad matrix model.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (press[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
   end

   // Count strobe cycles.
   initial strobe_cnt = 0;
   always @(negedge clk) if (key_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_strobe(input int bound, output int cyc, output bit ok);
      ok  = 1'b0;
      cyc = 0;
      for (int i = 0; i < bound; i++) begin
         step(1);
         cyc++;
         if (key_strobe === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_release(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         step(1);
         if (key_held === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_col(input logic [3:0] col, input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         step(1);
         if (col_out === col) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int cyc;
      bit ok;
      compared   = 0;
      mismatched = 0;
      press      = 16'h0000;
      rst        = 1'b1;

      // Reset values and idle sweep.
      step(2);
      chk("rst_col", {4'h0, col_out}, 8'h0E);
      chk("rst_code", {4'h0, key_code}, 8'h00);
      chk("rst_strobe", {7'h0, key_strobe}, 8'h00);
      chk("rst_held", {7'h0, key_held}, 8'h00);
      rst = 1'b0;
      step(3);
      chk("sweep_pre_tick", {4'h0, col_out}, 8'h0E);
      step(1);
      chk("sweep_col1", {4'h0, col_out}, 8'h0D);
      step(4);
      chk("sweep_col2", {4'h0, col_out}, 8'h0B);
      step(4);
      chk("sweep_col3", {4'h0, col_out}, 8'h07);
      step(4);
      chk("sweep_wrap", {4'h0, col_out}, 8'h0E);
      step(5);
      chk("sweep_col1_again", {4'h0, col_out}, 8'h0D);

      // Mid-cycle asynchronous reset.
      rst = 1'b1;
      #1;
      chk("async_rst_col", {4'h0, col_out}, 8'h0E);
      step(1);
      rst = 1'b0;
      step(3);
      chk("restart_pre_tick", {4'h0, col_out}, 8'h0E);
      step(1);
      chk("restart_col1", {4'h0, col_out}, 8'h0D);

      // Press (2,1).
      press = 16'h0200;
      wait_strobe(40, cyc, ok);
      chk("press_strobe_seen", {7'h0, ok}, 8'h01);
      chk("press_latency_ok", {7'h0, (cyc >= DT*CLK_DIV + 1) && (cyc <= SYNC_LAT + (DT+1)*CLK_DIV)}, 8'h01);
      chk("press_col_frozen", {4'h0, col_out}, 8'h0D);
      chk("press_code", {4'h0, key_code}, 8'h09);
      chk("press_held", {7'h0, key_held}, 8'h01);
      step(1);
      chk("press_strobe_1cyc", {7'h0, key_strobe}, 8'h00);
      chk("press_strobe_cnt", strobe_cnt[7:0], 8'h01);

      // One-tick release glitch while held.
      press = 16'h0000;
      step(CLK_DIV);
      press = 16'h0200;
      step(20);
      chk("glitch_held", {7'h0, key_held}, 8'h01);
      chk("glitch_no_strobe", strobe_cnt[7:0], 8'h01);
      chk("glitch_col", {4'h0, col_out}, 8'h0D);

      // Real release.
      press = 16'h0000;
      step(12);
      chk("release_not_early", {7'h0, key_held}, 8'h01);
      wait_release(20, ok);
      chk("release_seen", {7'h0, ok}, 8'h01);
      chk("release_col_adv", {4'h0, col_out}, 8'h0B);
      chk("release_code_kept", {4'h0, key_code}, 8'h09);
      chk("release_no_strobe", strobe_cnt[7:0], 8'h01);

      // Bounce on (0,3): low for two ticks only.
      press = 16'h0008;
      wait_col(4'b0111, 20, ok);
      chk("bounce_reach_col3", {7'h0, ok}, 8'h01);
      step(2*CLK_DIV);
      press = 16'h0000;
      step(CLK_DIV);
      chk("bounce_col_same", {4'h0, col_out}, 8'h07);
      chk("bounce_no_strobe", strobe_cnt[7:0], 8'h01);
      chk("bounce_code_kept", {4'h0, key_code}, 8'h09);
      chk("bounce_not_held", {7'h0, key_held}, 8'h00);
      step(CLK_DIV);
      chk("bounce_scan_resumed", {4'h0, col_out}, 8'h0E);

      // Priority: (1,2) and (3,2) together.
      press = 16'h4040;
      wait_strobe(40, cyc, ok);
      chk("prio_strobe_seen", {7'h0, ok}, 8'h01);
      chk("prio_code", {4'h0, key_code}, 8'h06);
      chk("prio_col", {4'h0, col_out}, 8'h0B);
      step(1);
      chk("prio_strobe_cnt", strobe_cnt[7:0], 8'h02);

      // Reset while held.
      step(3);
      chk("held_before_rst", {7'h0, key_held}, 8'h01);
      rst = 1'b1;
      #1;
      chk("held_rst_col", {4'h0, col_out}, 8'h0E);
      chk("held_rst_code", {4'h0, key_code}, 8'h00);
      chk("held_rst_strobe", {7'h0, key_strobe}, 8'h00);
      chk("held_rst_held", {7'h0, key_held}, 8'h00);
      press = 16'h0000;
      step(2);
      rst = 1'b0;
      step(3);
      chk("held_restart_pre_tick", {4'h0, col_out}, 8'h0E);
      step(1);
      chk("held_restart_col1", {4'h0, col_out}, 8'h0D);
      chk("held_restart_not_held", {7'h0, key_held}, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
